rs_dec_c1_corrector: RTL and testbench

Single-symbol Reed-Solomon corrector for the CD C1 stage. It sits directly downstream of `rs_dec_syndrome_calc` and consumes its four GF(2^8) syndromes when `o_ready` pulses. It then runs an iterative locator search and reports one of three outcomes: no error, one corrected error (position and magnitude), or uncorrectable. The result feeds the symbol-patch and erasure-flag logic ahead of the C2 deinterleaver.

---
 rtl/rs_dec_c1_corrector_if.sv | 29 ++
 rtl/rs_dec_c1_corrector.sv | 184 ++++++++++++++++++
 tb/tb_rs_dec_c1_corrector.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rs_dec_c1_corrector_if.sv
// Syndrome-in / result-out bundle between the C1 syndrome calculator,
// the single-symbol corrector and the downstream patch logic.
interface rs_dec_c1_corrector_if;
    // Handshake: i_valid is a one-cycle pulse qualifying i_s0..i_s3, with no
    // backpressure (a pulse while o_busy is high is dropped and flagged in
    // o_overrun); o_done is a one-cycle pulse qualifying o_status, o_err_idx
    // and o_err_mag, which then hold until the next o_done.
    logic       i_valid;
    logic [7:0] i_s0;
    logic [7:0] i_s1;
    logic [7:0] i_s2;
    logic [7:0] i_s3;
    logic       o_busy;
    logic       o_done;
    logic [1:0] o_status;
    logic [7:0] o_err_idx;
    logic [7:0] o_err_mag;
    logic       o_overrun;

    modport master (
        output i_valid, i_s0, i_s1, i_s2, i_s3,
        input  o_busy, o_done, o_status, o_err_idx, o_err_mag, o_overrun
    );

    modport slave (
        input  i_valid, i_s0, i_s1, i_s2, i_s3,
        output o_busy, o_done, o_status, o_err_idx, o_err_mag, o_overrun
    );
endinterface

// File: rtl/rs_dec_c1_corrector.sv
// Single-symbol RS corrector for CD C1: walks a locator k over the codeword
// until S0*alpha^(jk) reproduces S1..S3, or reports the frame uncorrectable.
module rs_dec_c1_corrector #(
    parameter int N_SYM = 32
) (
    input  logic                 i_clk,
    input  logic                 i_resb,
    rs_dec_c1_corrector_if.slave bus,
    output logic                 dbg_state
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } state_t;

    localparam logic [7:0] LAST_K = 8'(N_SYM - 1);

    localparam logic [1:0] RES_CLEAN   = 2'b00;
    localparam logic [1:0] RES_FIXED   = 2'b01;
    localparam logic [1:0] RES_UNCORR  = 2'b10;

    // Multiply by alpha modulo 0x11D: shift and fold the carry back in.
    function automatic logic [7:0] mul_a(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    endfunction

    function automatic logic [7:0] mul_a2(input logic [7:0] x);
        return mul_a(mul_a(x));
    endfunction

    function automatic logic [7:0] mul_a3(input logic [7:0] x);
        return mul_a(mul_a(mul_a(x)));
    endfunction

    state_t     state;
    state_t     state_nxt;

    logic [7:0] s0_q;
    logic [7:0] s1_q;
    logic [7:0] s2_q;
    logic [7:0] s3_q;
    logic [7:0] t1_q;
    logic [7:0] t2_q;
    logic [7:0] t3_q;
    logic [7:0] k_q;

    logic       done_q;
    logic [1:0] status_q;
    logic [7:0] idx_q;
    logic [7:0] mag_q;
    logic       overrun_q;

    logic       in_all_zero;
    logic       match;
    logic       at_last;

    logic       res_load;
    logic [1:0] res_status;
    logic [7:0] res_idx;
    logic [7:0] res_mag;
    logic       load_t;
    logic       step;

    assign in_all_zero = (bus.i_s0 == 8'h00) && (bus.i_s1 == 8'h00) &&
                         (bus.i_s2 == 8'h00) && (bus.i_s3 == 8'h00);
    assign match       = (t1_q == s1_q) && (t2_q == s2_q) && (t3_q == s3_q);
    assign at_last     = (k_q == LAST_K);

    always_ff @(posedge i_clk) begin
        if (!i_resb) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.i_valid && (bus.i_s0 != 8'h00)) begin
                    state_nxt = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (match || at_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        res_load   = 1'b0;
        res_status = RES_CLEAN;
        res_idx    = 8'h00;
        res_mag    = 8'h00;
        load_t     = 1'b0;
        step       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    if (bus.i_s0 != 8'h00) begin
                        load_t = 1'b1;
                    end else begin
                        // S0 = 0 cannot come from a single error: clean or hopeless.
                        res_load   = 1'b1;
                        res_status = in_all_zero ? RES_CLEAN : RES_UNCORR;
                    end
                end
            end
            ST_SEARCH: begin
                if (match) begin
                    res_load   = 1'b1;
                    res_status = RES_FIXED;
                    res_idx    = LAST_K - k_q;
                    res_mag    = s0_q;
                end else if (at_last) begin
                    res_load   = 1'b1;
                    res_status = RES_UNCORR;
                end else begin
                    step = 1'b1;
                end
            end
            default: begin
                res_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_resb) begin
            s0_q      <= 8'h00;
            s1_q      <= 8'h00;
            s2_q      <= 8'h00;
            s3_q      <= 8'h00;
            t1_q      <= 8'h00;
            t2_q      <= 8'h00;
            t3_q      <= 8'h00;
            k_q       <= 8'h00;
            done_q    <= 1'b0;
            status_q  <= RES_CLEAN;
            idx_q     <= 8'h00;
            mag_q     <= 8'h00;
            overrun_q <= 1'b0;
        end else begin
            done_q <= res_load;
            if (res_load) begin
                status_q <= res_status;
                idx_q    <= res_idx;
                mag_q    <= res_mag;
            end
            if (bus.i_valid && (state == ST_SEARCH)) begin
                overrun_q <= 1'b1;
            end
            if (load_t) begin
                s0_q <= bus.i_s0;
                s1_q <= bus.i_s1;
                s2_q <= bus.i_s2;
                s3_q <= bus.i_s3;
                t1_q <= bus.i_s0;
                t2_q <= bus.i_s0;
                t3_q <= bus.i_s0;
                k_q  <= 8'h00;
            end else if (step) begin
                t1_q <= mul_a(t1_q);
                t2_q <= mul_a2(t2_q);
                t3_q <= mul_a3(t3_q);
                k_q  <= k_q + 8'd1;
            end
        end
    end

    assign bus.o_busy    = (state == ST_SEARCH);
    assign bus.o_done    = done_q;
    assign bus.o_status  = status_q;
    assign bus.o_err_idx = idx_q;
    assign bus.o_err_mag = mag_q;
    assign bus.o_overrun = overrun_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_rs_dec_c1_corrector.sv
// Self-checking bench for rs_dec_c1_corrector: directed cases, a full
// position sweep and random frames against a GF(2^8) reference model.
module tb_rs_dec_c1_corrector;

    localparam int N_SYM = 32;
    localparam int W     = 26;

    logic clk  = 1'b0;
    logic resb = 1'b0;
    logic dbg_state;

    always #5 clk = ~clk;

    rs_dec_c1_corrector_if bus ();

    rs_dec_c1_corrector #(.N_SYM(N_SYM)) dut (
        .i_clk     (clk),
        .i_resb    (resb),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int             vectors = 0;
    int             fails   = 0;
    logic [W-1:0]   exp_q[$];

    // General multiplier (shift-and-add over 0x11D).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) r = r ^ x;
            y = y >> 1;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] gf_pow(input int n);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < (n % 255); i++) r = gf_mul(r, 8'h02);
        return r;
    endfunction

    // Expected {latency, status, index, magnitude} for one syndrome set.
    function automatic logic [W-1:0] model(input logic [7:0] s0, input logic [7:0] s1,
                                           input logic [7:0] s2, input logic [7:0] s3);
        if (s0 == 0 && s1 == 0 && s2 == 0 && s3 == 0) return {8'd1, 2'b00, 16'h0000};
        if (s0 == 0) return {8'd1, 2'b10, 16'h0000};
        for (int k = 0; k < N_SYM; k++) begin
            if (gf_mul(s0, gf_pow(k)) == s1 && gf_mul(s0, gf_pow(2 * k)) == s2 &&
                gf_mul(s0, gf_pow(3 * k)) == s3)
                return {8'(k + 2), 2'b01, 8'(N_SYM - 1 - k), s0};
        end
        return {8'(N_SYM + 1), 2'b10, 16'h0000};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {bus.o_busy, bus.o_done, bus.o_status, bus.o_err_idx, bus.o_err_mag,
                    bus.o_overrun}, 32'h0);
    endtask

    // Returns in the o_done cycle, so a caller may drive the next frame there.
    task automatic run_frame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                             input logic [7:0] s3, input int inject_at);
        logic [W-1:0] exp;
        int lat;
        exp_q.push_back(model(s0, s1, s2, s3));
        bus.i_valid = 1'b1;
        bus.i_s0 = s0; bus.i_s1 = s1; bus.i_s2 = s2; bus.i_s3 = s3;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        lat = 1;
        check("busy_after_accept", 32'(bus.o_busy), 32'(exp_q[0][25:18] > 8'd1));
        while (!bus.o_done && lat < N_SYM + 4) begin
            if (lat == inject_at) begin
                bus.i_valid = 1'b1;
                bus.i_s0 = 8'($urandom_range(1, 255)); bus.i_s1 = 8'($urandom);
                bus.i_s2 = 8'($urandom);               bus.i_s3 = 8'($urandom);
            end
            @(posedge clk); #1;
            bus.i_valid = 1'b0;
            lat++;
        end
        exp = exp_q.pop_front();
        if (!bus.o_done) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(lat), 32'(exp[25:18]));
            check("result", {14'h0, bus.o_status, bus.o_err_idx, bus.o_err_mag}, {14'h0, exp[17:0]});
            check("busy_at_done", 32'(bus.o_busy), 32'd0);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("idle_no_done", {bus.o_busy, bus.o_done}, 32'd0);
        end
    endtask

    task automatic make_syn(input logic [7:0] e, input int p, output logic [7:0] s[4]);
        for (int j = 0; j < 4; j++) s[j] = gf_mul(e, gf_pow(j * p));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s[4];
        logic [7:0] e;
        int p;

        bus.i_valid = 1'b0;
        bus.i_s0 = 8'h00; bus.i_s1 = 8'h00; bus.i_s2 = 8'h00; bus.i_s3 = 8'h00;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        resb = 1'b1;

        // Clean frame, single error at p=3, S0=0 uncorrectable
        run_frame(8'h00, 8'h00, 8'h00, 8'h00, 0);
        idle_cycles(2);
        run_frame(8'h5A, 8'hEA, 8'h03, 8'h18, 0);
        idle_cycles(1);
        run_frame(8'h00, 8'h02, 8'h04, 8'h08, 0);
        idle_cycles(1);
        check("overrun_clear", 32'(bus.o_overrun), 32'd0);

        // Inconsistent syndromes: full-length search with an ignored pulse at cycle 4
        run_frame(8'h01, 8'h02, 8'h04, 8'h09, 4);
        idle_cycles(1);
        check("overrun_set", 32'(bus.o_overrun), 32'd1);

        // Back-to-back: next frame driven in the o_done cycle
        make_syn(8'hC3, 10, s);
        run_frame(s[0], s[1], s[2], s[3], 0);
        make_syn(8'h17, 25, s);
        run_frame(s[0], s[1], s[2], s[3], 0);
        run_frame(8'h00, 8'h00, 8'h00, 8'h00, 0);
        idle_cycles(1);
        check("overrun_sticky", 32'(bus.o_overrun), 32'd1);

        // Reset mid-search; valid during reset must be ignored
        bus.i_valid = 1'b1;
        bus.i_s0 = 8'h01; bus.i_s1 = 8'h02; bus.i_s2 = 8'h04; bus.i_s3 = 8'h09;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        resb = 1'b0;
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        check_reset_outputs("reset_mid_search_1");
        @(posedge clk); #1;
        check_reset_outputs("reset_mid_search_2");
        resb = 1'b1;
        make_syn(8'h99, 20, s);
        run_frame(s[0], s[1], s[2], s[3], 0);
        idle_cycles(2);

        // Sweep every position with a random nonzero magnitude
        for (int pp = 0; pp < N_SYM; pp++) begin
            e = 8'($urandom_range(1, 255));
            make_syn(e, pp, s);
            run_frame(s[0], s[1], s[2], s[3], 0);
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end

        // Random frames: single errors, random syndromes, double errors
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 2))
                0: begin
                    p = $urandom_range(0, N_SYM - 1);
                    make_syn(8'($urandom_range(1, 255)), p, s);
                end
                1: begin
                    for (int j = 0; j < 4; j++) s[j] = 8'($urandom);
                end
                default: begin
                    logic [7:0] s2[4];
                    make_syn(8'($urandom_range(1, 255)), $urandom_range(0, N_SYM - 1), s);
                    make_syn(8'($urandom_range(1, 255)), $urandom_range(0, N_SYM - 1), s2);
                    for (int j = 0; j < 4; j++) s[j] = s[j] ^ s2[j];
                end
            endcase
            run_frame(s[0], s[1], s[2], s[3], 0);
            if ($urandom_range(0, 2) == 0) idle_cycles(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
